scr1_tb_test_monitor: RTL and testbench
=======================================

Name: scr1_tb_test_monitor

Overview:
- Synthesizable, parametrised test-run sequencer and exit monitor for SCR1 testbenches.
- For each test, it pulses DUT reset, then watches the PC of up to NUM_HARTS harts for the exit address and samples each hart's a0 (x10) result.
- It enforces an optional cycle timeout and accumulates pass/total counters.
- It replaces ad-hoc run loops in the bench top and serves AHB and AXI benches alike.

Parameters:
- NUM_HARTS, 1, number of monitored harts (1..8)
- XLEN, 32, hart register/PC width
- EXIT_ADDR, 32'h004800F8, PC value that marks test completion
- RST_CYCLES, 4, cycles dut_rst_n is held low per test (>=1)
- TMO_W, 32, timeout counter width
- CNT_W, 16, width of the result counters

Ports:
- clk  in  1  bench clock
- rst_n  in  1  synchronous active-low reset
- test_start  in  1  one-cycle request to run the next test
- tmo_cycles  in  TMO_W  RUN-cycle budget; 0 = no timeout
- hart_en  in  NUM_HARTS  participating-hart mask, sampled at test_start
- hart_pc  in  NUM_HARTS*XLEN  current PC per hart, hart i at [i*XLEN +: XLEN]
- hart_a0  in  NUM_HARTS*XLEN  x10 value per hart, same packing
- dut_rst_n  out  1  reset to DUT, registered
- busy  out  1  high in RESET, RUN or DONE
- test_done  out  1  one-cycle completion pulse
- test_pass  out  1  result of last test, held until next accepted start
- test_timeout  out  1  last test ended by timeout, held likewise
- hart_exit  out  NUM_HARTS  per-hart exit-seen flags
- hart_fail  out  NUM_HARTS  per-hart nonzero-a0-at-exit flags
- tests_total  out  CNT_W  completed tests, saturating
- tests_passed  out  CNT_W  passed tests, saturating

Behaviour:
- All state is registered on posedge clk. The reset is checked before any other condition.
- rst_n low, including mid-test, forces the following, and no test_done is emitted for an aborted test:
  - state = IDLE, dut_rst_n = 0, busy = 0, test_done = 0, test_pass = 0, test_timeout = 0
  - hart_exit = 0, hart_fail = 0, counters = 0, timeout counter = 0
- FSM states: IDLE, RESET, RUN, DONE.
- IDLE:
  - dut_rst_n = 1 from the first cycle after rst_n deasserts.
  - test_start = 1 at cycle T → RESET at T+1.
  - On acceptance: latch hart_en to en_q; clear hart_exit, hart_fail, test_pass, test_timeout and the timeout counter.
- test_start while not in IDLE is ignored (no queuing).
- RESET:
  - dut_rst_n = 0 for exactly RST_CYCLES cycles (T+1 .. T+RST_CYCLES), counted by an internal down-counter.
  - Then RUN, with dut_rst_n = 1 from T+RST_CYCLES+1.
- RUN, each cycle, for each hart i with en_q[i] = 1 and hart_exit[i] = 0:
  - If hart_pc[i] == EXIT_ADDR, set hart_exit[i] and set hart_fail[i] = (hart_a0[i] != 0).
  - Harts with en_q[i] = 0 are never flagged.
  - A hart's flags are frozen after its first exit; later PC/a0 values are ignored.
  - all_exit = ((hart_exit | new_exits) & en_q) == en_q, evaluated with this cycle's updates.
  - Timeout counter increments each RUN cycle, saturating at all-ones; the first RUN cycle sees count 1.
  - tmo_hit = (tmo_cycles != 0) and (count == tmo_cycles).
  - If en_q == 0: go to DONE immediately after the first RUN cycle, with test_pass = 0.
  - Else if all_exit: go to DONE.
  - Else if tmo_hit: go to DONE with test_timeout = 1.
  - If all_exit and tmo_hit occur in the same cycle, completion wins and test_timeout stays 0.
- DONE (one cycle):
  - test_done = 1.
  - test_pass = (en_q != 0) & ~test_timeout & ~|(hart_fail & en_q).
  - tests_total += 1; tests_passed += test_pass. Each counter holds at 2^CNT_W-1.
  - Next state IDLE; dut_rst_n stays 1.
- Latency: last exit sampled in RUN cycle E → DONE and test_done in cycle E+1. test_pass is valid in the same cycle as test_done.
- busy = (state != IDLE), registered together with the state.
- hart_pc and hart_a0 are not sampled outside RUN.

Test Plan:
- Single hart, TMO 0, RST_CYCLES = 4, start at T, PC reaches 0x004800F8 with a0 = 0 at RUN cycle 10 → dut_rst_n low T+1..T+4; test_done in the next cycle with test_pass = 1; total = 1, passed = 1.
- Single hart, exit with a0 = 3 → test_pass = 0, hart_fail = 1; total increments, passed unchanged.
- NUM_HARTS = 4, hart_en = 4'b1011, harts 0/1/3 exit at cycles 5/9/7 with a0 = 0 and hart 2 never exits → done one cycle after cycle 9, pass = 1, hart_exit = 4'b1011.
- tmo_cycles = 20, no exit → done after the 20th RUN cycle, test_timeout = 1, pass = 0. Repeat with the exit on the 20th cycle → pass = 1, timeout = 0.
- rst_n low mid-RUN, then test_start while busy → all outputs at reset values, no test_done; a start during busy is ignored and a start after returning to IDLE is accepted.
- CNT_W = 2, five passing tests → tests_total and tests_passed saturate at 3.

Source files
------------

// File: rtl/scr1_tb_test_monitor_if.sv
// Control/status bundle between a bench top and scr1_tb_test_monitor.
// The master side is the bench. The slave side is the monitor.
interface scr1_tb_test_monitor_if #(
    parameter int NUM_HARTS = 1,
    parameter int XLEN      = 32,
    parameter int TMO_W     = 32,
    parameter int CNT_W     = 16
);
    logic                      test_start;
    logic [TMO_W-1:0]          tmo_cycles;
    logic [NUM_HARTS-1:0]      hart_en;
    logic [NUM_HARTS*XLEN-1:0] hart_pc;
    logic [NUM_HARTS*XLEN-1:0] hart_a0;
    logic                      dut_rst_n;
    logic                      busy;
    logic                      test_done;
    logic                      test_pass;
    logic                      test_timeout;
    logic [NUM_HARTS-1:0]      hart_exit;
    logic [NUM_HARTS-1:0]      hart_fail;
    logic [CNT_W-1:0]          tests_total;
    logic [CNT_W-1:0]          tests_passed;

    modport master (
        output test_start, tmo_cycles, hart_en, hart_pc, hart_a0,
        input  dut_rst_n, busy, test_done, test_pass, test_timeout,
               hart_exit, hart_fail, tests_total, tests_passed
    );

    modport slave (
        input  test_start, tmo_cycles, hart_en, hart_pc, hart_a0,
        output dut_rst_n, busy, test_done, test_pass, test_timeout,
               hart_exit, hart_fail, tests_total, tests_passed
    );
endinterface

// File: rtl/scr1_tb_test_monitor.sv
// Test-run sequencer: pulses DUT reset, watches hart PCs for the exit address, grades a0 and counts results.
// test_done comes one cycle after the last exit or the timeout. There is no backpressure, and a start while busy is dropped.
module scr1_tb_test_monitor #(
    parameter int          NUM_HARTS  = 1,
    parameter int          XLEN       = 32,
    parameter logic [31:0] EXIT_ADDR  = 32'h004800F8,
    parameter int          RST_CYCLES = 4,
    parameter int          TMO_W      = 32,
    parameter int          CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scr1_tb_test_monitor_if.slave   bus
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_RUN, ST_DONE} state_e;

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 dut_rst_n_q, dut_rst_n_d;
    logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [NUM_HARTS-1:0] en_q, en_d;
    logic [NUM_HARTS-1:0] exit_q, exit_d;
    logic [NUM_HARTS-1:0] fail_q, fail_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     passed_q, passed_d;

    logic [NUM_HARTS-1:0] new_exit;
    logic [TMO_W-1:0]     tmo_inc;
    logic                 all_exit;
    logic                 tmo_hit;

    always_comb begin
        new_exit = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            new_exit[i] = en_q[i] & ~exit_q[i] &
                          (bus.hart_pc[i*XLEN +: XLEN] == XLEN'(EXIT_ADDR));
        end
        all_exit = (((exit_q | new_exit) & en_q) == en_q);
        tmo_inc  = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        tmo_hit  = (bus.tmo_cycles != '0) && (tmo_inc == bus.tmo_cycles);
    end

    always_comb begin
        state_d     = state_q;
        dut_rst_n_d = 1'b1;
        rst_cnt_d   = rst_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        en_d        = en_q;
        exit_d      = exit_q;
        fail_d      = fail_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        total_d     = total_q;
        passed_d    = passed_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.test_start) begin
                    state_d     = ST_RESET;
                    dut_rst_n_d = 1'b0;
                    rst_cnt_d   = RC_W'(RST_CYCLES - 1);
                    en_d        = bus.hart_en;
                    exit_d      = '0;
                    fail_d      = '0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    tmo_cnt_d   = '0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    dut_rst_n_d = 1'b0;
                    rst_cnt_d   = rst_cnt_q - RC_W'(1);
                end
            end
            ST_RUN: begin
                exit_d    = exit_q | new_exit;
                tmo_cnt_d = tmo_inc;
                for (int i = 0; i < NUM_HARTS; i++) begin
                    if (new_exit[i]) begin
                        fail_d[i] = (bus.hart_a0[i*XLEN +: XLEN] != '0);
                    end
                end
                // Completion outranks a coincident timeout.
                if (en_q == '0 || all_exit) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Grade and count on entry to DONE so test_pass is valid alongside test_done.
        if (state_q == ST_RUN && state_d == ST_DONE) begin
            done_d = 1'b1;
            pass_d = (en_q != '0) & ~timeout_d & ~|(fail_d & en_q);
            if (total_q != '1) begin
                total_d = total_q + CNT_W'(1);
            end
            if (pass_d && passed_q != '1) begin
                passed_d = passed_q + CNT_W'(1);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            dut_rst_n_q <= 1'b0;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            en_q        <= '0;
            exit_q      <= '0;
            fail_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            total_q     <= '0;
            passed_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            dut_rst_n_q <= dut_rst_n_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            en_q        <= en_d;
            exit_q      <= exit_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            total_q     <= total_d;
            passed_q    <= passed_d;
        end
    end

    assign bus.dut_rst_n    = dut_rst_n_q;
    assign bus.busy         = busy_q;
    assign bus.test_done    = done_q;
    assign bus.test_pass    = pass_q;
    assign bus.test_timeout = timeout_q;
    assign bus.hart_exit    = exit_q;
    assign bus.hart_fail    = fail_q;
    assign bus.tests_total  = total_q;
    assign bus.tests_passed = passed_q;
endmodule

// File: tb/tb_scr1_tb_test_monitor.sv
// Directed bench: a 4-hart monitor for sequencing and grading, a 1-hart CNT_W=2 monitor for saturation.
module tb_scr1_tb_test_monitor;
    localparam logic [31:0] EXIT = 32'h004800F8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scr1_tb_test_monitor_if #(.NUM_HARTS(4), .XLEN(32), .TMO_W(32), .CNT_W(16)) m4 ();
    scr1_tb_test_monitor_if #(.NUM_HARTS(1), .XLEN(32), .TMO_W(32), .CNT_W(2))  m2 ();

    scr1_tb_test_monitor #(.NUM_HARTS(4), .XLEN(32), .EXIT_ADDR(EXIT), .RST_CYCLES(4),
                           .TMO_W(32), .CNT_W(16))
        u_mon4 (.clk(clk), .rst_n(rst_n), .bus(m4.slave));

    scr1_tb_test_monitor #(.NUM_HARTS(1), .XLEN(32), .EXIT_ADDR(EXIT), .RST_CYCLES(4),
                           .TMO_W(32), .CNT_W(2))
        u_mon2 (.clk(clk), .rst_n(rst_n), .bus(m2.slave));

    int          n_chk = 0;
    int          n_bad = 0;
    int          ex_cyc [4];
    logic [31:0] ex_a0  [4];
    int          xs;
    int          last_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Hart h hits EXIT at RUN cycle ex_cyc[h] and then parks there with a different a0.
    task automatic drive_pcs(input int n);
        for (int h = 0; h < 4; h++) begin
            if (ex_cyc[h] != 0 && n >= ex_cyc[h]) begin
                m4.hart_pc[h*32 +: 32] = EXIT;
                m4.hart_a0[h*32 +: 32] = (n == ex_cyc[h]) ? ex_a0[h] : 32'd5;
            end else begin
                m4.hart_pc[h*32 +: 32] = 32'h100 + n;
                m4.hart_a0[h*32 +: 32] = 32'd9;
            end
        end
    endtask

    task automatic set_ex(input int c0, input int c1, input int c2, input int c3,
                          input logic [31:0] a0_0, input logic [31:0] a0_1,
                          input logic [31:0] a0_2, input logic [31:0] a0_3);
        ex_cyc[0] = c0; ex_cyc[1] = c1; ex_cyc[2] = c2; ex_cyc[3] = c3;
        ex_a0[0] = a0_0; ex_a0[1] = a0_1; ex_a0[2] = a0_2; ex_a0[3] = a0_3;
    endtask

    // Returns at the negedge of the test_done cycle.
    task automatic do_test(input logic [3:0] en, input logic [31:0] tmo,
                           input int exp_last, input string tg);
        logic [3:0] lo;
        drive_pcs(0);
        @(negedge clk);
        m4.test_start = 1'b1;
        m4.hart_en    = en;
        m4.tmo_cycles = tmo;
        @(negedge clk);
        m4.test_start = 1'b0;
        m4.hart_en    = ~en;
        chk({tg, ".busy"}, 32'(m4.busy), 32'd1);
        lo[0] = m4.dut_rst_n;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            lo[k] = m4.dut_rst_n;
        end
        chk({tg, ".rst_lo"}, 32'(lo), 32'd0);
        last_run = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) chk({tg, ".rst_hi"}, 32'(m4.dut_rst_n), 32'd1);
            if (m4.test_done) begin
                last_run = n - 1;
                break;
            end
            drive_pcs(n);
            m4.test_start = (n == xs);
            if (n == xs) m4.hart_en = 4'h0;
        end
        m4.test_start = 1'b0;
        chk({tg, ".last_run"}, last_run, exp_last);
    endtask

    task automatic post(input string tg, input int tot, input int pas);
        @(negedge clk);
        chk({tg, ".done_1cyc"}, 32'(m4.test_done), 32'd0);
        chk({tg, ".idle"}, 32'(m4.busy), 32'd0);
        chk({tg, ".total"}, 32'(m4.tests_total), tot);
        chk({tg, ".passed"}, 32'(m4.tests_passed), pas);
        drive_pcs(0);
    endtask

    task automatic res(input string tg, input logic p, input logic t,
                       input logic [3:0] ex, input logic [3:0] fl);
        chk({tg, ".pass"}, 32'(m4.test_pass), 32'(p));
        chk({tg, ".timeout"}, 32'(m4.test_timeout), 32'(t));
        chk({tg, ".exit"}, 32'(m4.hart_exit), 32'(ex));
        chk({tg, ".fail"}, 32'(m4.hart_fail), 32'(fl));
    endtask

    initial begin
        logic saw;
        int   got;
        m4.test_start = 1'b0; m4.tmo_cycles = '0; m4.hart_en = '0;
        m4.hart_pc = '0; m4.hart_a0 = '0;
        m2.test_start = 1'b0; m2.tmo_cycles = '0; m2.hart_en = 1'b1;
        m2.hart_pc = EXIT; m2.hart_a0 = '0;
        xs = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst.dut_rst_n", 32'(m4.dut_rst_n), 32'd0);
        chk("rst.busy", 32'(m4.busy), 32'd0);
        chk("rst.done", 32'(m4.test_done), 32'd0);
        chk("rst.total", 32'(m4.tests_total), 32'd0);
        chk("rst.exit", 32'(m4.hart_exit), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.dut_rst_n", 32'(m4.dut_rst_n), 32'd1);

        set_ex(10, 0, 0, 0, 0, 0, 0, 0);
        do_test(4'b0001, 0, 10, "t1");
        res("t1", 1'b1, 1'b0, 4'b0001, 4'b0000);
        post("t1", 1, 1);

        set_ex(6, 0, 0, 0, 3, 0, 0, 0);
        do_test(4'b0001, 0, 6, "t2");
        res("t2", 1'b0, 1'b0, 4'b0001, 4'b0001);
        post("t2", 2, 1);

        set_ex(5, 9, 3, 7, 0, 0, 7, 0);
        do_test(4'b1011, 0, 9, "t3");
        res("t3", 1'b1, 1'b0, 4'b1011, 4'b0000);
        post("t3", 3, 2);

        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        do_test(4'b0001, 20, 20, "t4");
        res("t4", 1'b0, 1'b1, 4'b0000, 4'b0000);
        post("t4", 4, 2);

        set_ex(20, 0, 0, 0, 0, 0, 0, 0);
        do_test(4'b0001, 20, 20, "t5");
        res("t5", 1'b1, 1'b0, 4'b0001, 4'b0000);
        post("t5", 5, 3);

        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        do_test(4'b0000, 0, 1, "t6");
        res("t6", 1'b0, 1'b0, 4'b0000, 4'b0000);
        post("t6", 6, 3);

        set_ex(3, 8, 0, 0, 0, 0, 0, 0);
        do_test(4'b0011, 0, 8, "t7");
        res("t7", 1'b1, 1'b0, 4'b0011, 4'b0000);
        post("t7", 7, 4);

        // Abort a running test with rst_n.
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        drive_pcs(0);
        @(negedge clk);
        m4.test_start = 1'b1; m4.hart_en = 4'b0001; m4.tmo_cycles = 0;
        @(negedge clk);
        m4.test_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort.running", 32'(m4.busy), 32'd1);
        rst_n = 1'b0;
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw |= m4.test_done;
        end
        chk("abort.busy", 32'(m4.busy), 32'd0);
        chk("abort.dut_rst_n", 32'(m4.dut_rst_n), 32'd0);
        chk("abort.total", 32'(m4.tests_total), 32'd0);
        chk("abort.passed", 32'(m4.tests_passed), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            saw |= m4.test_done;
        end
        chk("abort.no_done", 32'(saw), 32'd0);
        chk("abort.idle_rst_hi", 32'(m4.dut_rst_n), 32'd1);

        xs = 5;
        do_test(4'b0001, 30, 30, "busy_start");
        res("busy_start", 1'b0, 1'b1, 4'b0000, 4'b0000);
        post("busy_start", 1, 0);
        xs = 0;

        set_ex(4, 0, 0, 0, 0, 0, 0, 0);
        do_test(4'b0001, 0, 4, "after");
        res("after", 1'b1, 1'b0, 4'b0001, 4'b0000);
        post("after", 2, 1);

        // Saturation on the CNT_W=2 monitor: every test passes on its first RUN cycle.
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            m2.test_start = 1'b1;
            @(negedge clk);
            m2.test_start = 1'b0;
            got = 0;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (m2.test_done) begin
                    got = 1;
                    break;
                end
            end
            chk("sat.done", got, 1);
            chk("sat.pass", 32'(m2.test_pass), 32'd1);
            @(negedge clk);
            chk("sat.total", 32'(m2.tests_total), (t < 3) ? t + 1 : 3);
            chk("sat.passed", 32'(m2.tests_passed), (t < 3) ? t + 1 : 3);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
